// File: rtl/k_dragonfly_feeder.sv
// Ping-pong frame buffer that reorders one N-point frame into N/4 radix-4 groups with twiddles.
// Define K_FEEDER_SCALE_EN to carry a per-frame cfg_scaling code to m_scaling (otherwise 2'b00).
module k_dragonfly_feeder #(
    parameter int N  = 64,
    parameter int AW = $clog2(N/4)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [63:0]   s_data,
`ifdef K_FEEDER_SCALE_EN
    input  logic [1:0]    cfg_scaling,
`endif
    output logic [AW-1:0] tw_addr,
    input  logic [63:0]   tw_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [63:0]   m_in0,
    output logic [63:0]   m_in1,
    output logic [63:0]   m_in2,
    output logic [63:0]   m_in3,
    output logic [63:0]   m_twiddle,
    output logic [1:0]    m_scaling
);

    localparam int G  = N / 4;
    localparam int IW = AW + 2;

    typedef enum logic {
        BANK_EMPTY = 1'b0,
        BANK_FULL  = 1'b1
    } bank_state_e;

    typedef struct packed {
        logic [63:0] in0;
        logic [63:0] in1;
        logic [63:0] in2;
        logic [63:0] in3;
        logic [63:0] twiddle;
        logic [1:0]  scaling;
        logic        bank;
        logic        last;
    } grp_t;

    // Both ports transfer on a cycle where valid && ready are high at the rising edge;
    // valid never depends on ready, and m_* stays frozen while m_valid && !m_ready.
    logic s_hs;
    logic m_pop;

    bank_state_e bank_q [2];
    bank_state_e bank_d [2];
    logic          w_bank_q, w_bank_d;
    logic [IW-1:0] w_idx_q, w_idx_d;
    logic          r_bank_q, r_bank_d;
    logic [AW-1:0] k_q, k_d;

    logic          rd_issue;
    logic [1:0]    slots_used;
    logic          rd_vld_q;
    logic          rd_bank_q;
    logic          rd_last_q;
    logic [1:0]    rd_scale_q;
    logic [1:0]    frame_scale;
    logic [63:0]   rd_data_q [4];

    logic [63:0]   mem_q [0:1][0:3][0:G-1];

    grp_t          fifo_q [2];
    logic          fifo_wr_q;
    logic          fifo_rd_q;
    logic [1:0]    fifo_cnt_q;
    grp_t          push_grp;
    grp_t          head;

    assign head    = fifo_q[fifo_rd_q];
    assign m_valid = (fifo_cnt_q != 2'd0);
    assign m_pop   = m_valid && m_ready;
    assign s_ready = (bank_q[w_bank_q] == BANK_EMPTY);
    assign s_hs    = s_valid && s_ready;
    assign tw_addr = k_q;

    // Count this cycle's pop as freed space so the FIFO can stream one group per cycle.
    assign slots_used = fifo_cnt_q - {1'b0, m_pop} + {1'b0, rd_vld_q};
    assign rd_issue   = (bank_q[r_bank_q] == BANK_FULL) && (slots_used < 2'd2);

`ifdef K_FEEDER_SCALE_EN
    logic [1:0] scale_q [2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scale_q[0] <= 2'b00;
            scale_q[1] <= 2'b00;
        end else if (s_hs && (w_idx_q == '0)) begin
            scale_q[w_bank_q] <= cfg_scaling;
        end
    end

    assign frame_scale = scale_q[r_bank_q];
`else
    assign frame_scale = 2'b00;
`endif

    always_comb begin
        bank_d   = bank_q;
        w_bank_d = w_bank_q;
        w_idx_d  = w_idx_q;
        r_bank_d = r_bank_q;
        k_d      = k_q;

        if (s_hs) begin
            if (w_idx_q == IW'(N - 1)) begin
                bank_d[w_bank_q] = BANK_FULL;
                w_bank_d         = ~w_bank_q;
                w_idx_d          = '0;
            end else begin
                w_idx_d = w_idx_q + 1'b1;
            end
        end

        // The last group of a frame leaving the FIFO releases its bank to the writer.
        if (m_pop && head.last) begin
            bank_d[head.bank] = BANK_EMPTY;
        end

        if (rd_issue) begin
            if (k_q == AW'(G - 1)) begin
                k_d      = '0;
                r_bank_d = ~r_bank_q;
            end else begin
                k_d = k_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q[0]  <= BANK_EMPTY;
            bank_q[1]  <= BANK_EMPTY;
            w_bank_q   <= 1'b0;
            w_idx_q    <= '0;
            r_bank_q   <= 1'b0;
            k_q        <= '0;
            rd_vld_q   <= 1'b0;
            rd_bank_q  <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_scale_q <= 2'b00;
        end else begin
            bank_q   <= bank_d;
            w_bank_q <= w_bank_d;
            w_idx_q  <= w_idx_d;
            r_bank_q <= r_bank_d;
            k_q      <= k_d;
            rd_vld_q <= rd_issue;
            if (rd_issue) begin
                rd_bank_q  <= r_bank_q;
                rd_last_q  <= (k_q == AW'(G - 1));
                rd_scale_q <= frame_scale;
            end
        end
    end

    // Read and write never target the same bank: reads need FULL, writes need EMPTY.
    always_ff @(posedge clk) begin
        if (s_hs) begin
            mem_q[w_bank_q][w_idx_q[IW-1 -: 2]][w_idx_q[AW-1:0]] <= s_data;
        end
        if (rd_issue) begin
            for (int q = 0; q < 4; q++) begin
                rd_data_q[q] <= mem_q[r_bank_q][q][k_q];
            end
        end
    end

    always_comb begin
        push_grp         = '0;
        push_grp.in0     = rd_data_q[0];
        push_grp.in2     = rd_data_q[1];
        push_grp.in1     = rd_data_q[2];
        push_grp.in3     = rd_data_q[3];
        push_grp.twiddle = tw_data;
        push_grp.scaling = rd_scale_q;
        push_grp.bank    = rd_bank_q;
        push_grp.last    = rd_last_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            fifo_wr_q  <= 1'b0;
            fifo_rd_q  <= 1'b0;
            fifo_cnt_q <= 2'd0;
        end else begin
            if (rd_vld_q) begin
                fifo_q[fifo_wr_q] <= push_grp;
                fifo_wr_q         <= ~fifo_wr_q;
            end
            if (m_pop) begin
                fifo_rd_q <= ~fifo_rd_q;
            end
            fifo_cnt_q <= fifo_cnt_q + {1'b0, rd_vld_q} - {1'b0, m_pop};
        end
    end

    assign m_in0     = head.in0;
    assign m_in1     = head.in1;
    assign m_in2     = head.in2;
    assign m_in3     = head.in3;
    assign m_twiddle = head.twiddle;
    assign m_scaling = head.scaling;

endmodule

// File: tb/tb_k_dragonfly_feeder.sv
// Directed bench for k_dragonfly_feeder at N=16: table-checked first frame, stall/backpressure,
// random m_ready, mid-frame reset, and per-frame scaling when K_FEEDER_SCALE_EN is defined.
module tb_k_dragonfly_feeder;
  localparam int N_T  = 16;
  localparam int AW_T = 2;
  localparam int W    = 322;

  typedef struct {
    logic [63:0] in0;
    logic [63:0] in1;
    logic [63:0] in2;
    logic [63:0] in3;
    logic [63:0] tw;
  } grp_vec_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [63:0]     s_data = '0;
`ifdef K_FEEDER_SCALE_EN
  logic [1:0]      cfg_scaling = 2'b00;
`endif
  logic [AW_T-1:0] tw_addr;
  logic [63:0]     tw_data;
  logic            m_valid;
  logic            m_ready = 1'b0;
  logic [63:0]     m_in0, m_in1, m_in2, m_in3, m_twiddle;
  logic [1:0]      m_scaling;

  k_dragonfly_feeder #(.N(N_T), .AW(AW_T)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
`ifdef K_FEEDER_SCALE_EN
    .cfg_scaling(cfg_scaling),
`endif
    .tw_addr(tw_addr), .tw_data(tw_data),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_in0(m_in0), .m_in1(m_in1), .m_in2(m_in2), .m_in3(m_in3),
    .m_twiddle(m_twiddle), .m_scaling(m_scaling)
  );

  // clock / reset / twiddle ROM (one-cycle latency, W^k = k)
  always #5 clk = ~clk;
  always @(posedge clk) tw_data <= 64'(tw_addr);

  int             n_cmp = 0;
  int             n_fail = 0;
  logic [W-1:0]   exp_q[$];
  logic [63:0]    frame_buf [16];
  grp_vec_t       tbl [4];
  logic           mon_en = 1'b0;
  logic           rand_mr = 1'b0;
  logic           stall_prev = 1'b0;
  logic [W-1:0]   prev_head = '0;
  logic           s_hs, m_hs, mv_smp, sr_smp;
  logic [W-1:0]   head_smp;
  logic [AW_T-1:0] tw_smp;

  task automatic check_w(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  // scoreboard: handshake pops expected queue; held outputs must not move during stalls
  task automatic observe();
    logic [W-1:0] head;
    head     = {m_in0, m_in1, m_in2, m_in3, m_twiddle, m_scaling};
    s_hs     = s_valid && s_ready;
    m_hs     = m_valid && m_ready;
    mv_smp   = m_valid;
    sr_smp   = s_ready;
    head_smp = head;
    tw_smp   = tw_addr;
    if (mon_en) begin
      if (stall_prev) begin
        check_bit("stall_valid", m_valid, 1'b1);
        check_w("stall_data", head, prev_head);
      end
      if (m_hs) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL extra_group: got %h required no group", head);
        end else begin
          check_w("group", head, exp_q.pop_front());
        end
      end
      stall_prev = m_valid && !m_ready;
      prev_head  = head;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    if (rand_mr) m_ready = ($urandom_range(0, 1) == 1);
  endtask

  task automatic do_reset();
    mon_en  = 1'b0;
    rand_mr = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    rst_n   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n      = 1'b1;
    stall_prev = 1'b0;
    exp_q.delete();
  endtask

  task automatic push_frame_exp(input logic [1:0] sc);
    for (int k = 0; k < 4; k++)
      exp_q.push_back({frame_buf[k], frame_buf[k+8], frame_buf[k+4], frame_buf[k+12], 64'(k), sc});
  endtask

  task automatic send_frame(input logic [1:0] sc0, input logic [1:0] sc_mid, input logic gaps);
    int i = 0;
    int guard = 0;
    logic [1:0] exp_sc;
    while (i < N_T && guard < 400) begin
      s_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_data  = frame_buf[i];
`ifdef K_FEEDER_SCALE_EN
      cfg_scaling = (i < 5) ? sc0 : sc_mid;
`endif
      tick();
      if (s_hs) i++;
      guard++;
    end
    s_valid = 1'b0;
    check_w("send_done", W'(i), W'(N_T));
`ifdef K_FEEDER_SCALE_EN
    exp_sc = sc0;
`else
    exp_sc = 2'b00;
    if (sc_mid != sc0) exp_sc = 2'b00;
`endif
    push_frame_exp(exp_sc);
  endtask

  task automatic drain(input string name, input int budget);
    int g = 0;
    while (exp_q.size() != 0 && g < budget) begin
      tick();
      g++;
    end
    check_w(name, W'(exp_q.size()), W'(0));
    tick();
    check_bit("idle_after_drain", mv_smp, 1'b0);
  endtask

  function automatic logic [63:0] t2_data(input int a);
    return {32'(a / 16 + 1), 32'(a % 16)};
  endfunction

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int mh;
    int guard;
    logic watch_next;

    tbl[0] = '{64'd0, 64'd8,  64'd4, 64'd12, 64'd0};
    tbl[1] = '{64'd1, 64'd9,  64'd5, 64'd13, 64'd1};
    tbl[2] = '{64'd2, 64'd10, 64'd6, 64'd14, 64'd2};
    tbl[3] = '{64'd3, 64'd11, 64'd7, 64'd15, 64'd3};

    // reset values
    do_reset();
    tick();
    check_bit("rst_s_ready", sr_smp, 1'b1);
    check_bit("rst_m_valid", mv_smp, 1'b0);
    check_w("rst_outputs", head_smp, '0);
    check_w("rst_tw_addr", W'(tw_smp), W'(0));

    // frame of s_data = i, m_ready high: latency and operand mapping from the table
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) frame_buf[i] = 64'(i);
    send_frame(2'b00, 2'b00, 1'b0);
    tick();
    check_bit("t1_latency_c1", mv_smp, 1'b0);
    tick();
    check_bit("t1_latency_c2", mv_smp, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_bit("t1_valid", mv_smp, 1'b1);
      check_w("t1_group", head_smp, {tbl[k].in0, tbl[k].in1, tbl[k].in2, tbl[k].in3, tbl[k].tw, 2'b00});
    end
    tick();
    check_bit("t1_idle", mv_smp, 1'b0);
    exp_q.delete();

    // three back-to-back frames against a stalled consumer
    do_reset();
    mon_en = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 16; i++) frame_buf[i] = t2_data(f * 16 + i);
      push_frame_exp(2'b00);
    end
    acc = 0;
    guard = 0;
    while (acc < 32 && guard < 100) begin
      s_valid = 1'b1;
      s_data  = t2_data(acc);
      tick();
      if (s_hs) acc++;
      guard++;
    end
    check_w("t2_accepted", W'(acc), W'(32));
    s_valid = 1'b1;
    s_data  = t2_data(acc);
    repeat (3) begin
      tick();
      check_bit("t2_s_ready_low", sr_smp, 1'b0);
      check_bit("t2_m_valid_held", mv_smp, 1'b1);
    end
    m_ready = 1'b1;
    mh = 0;
    guard = 0;
    watch_next = 1'b0;
    while ((acc < 48 || exp_q.size() != 0) && guard < 300) begin
      s_valid = (acc < 48);
      s_data  = t2_data(acc);
      tick();
      if (watch_next) begin
        check_bit("t2_s_ready_reassert", sr_smp, 1'b1);
        watch_next = 1'b0;
      end
      if (s_hs) acc++;
      if (m_hs) begin
        mh++;
        if (mh == 4) begin
          check_bit("t2_s_ready_at_last", sr_smp, 1'b0);
          watch_next = 1'b1;
        end
      end
      guard++;
    end
    s_valid = 1'b0;
    check_w("t2_groups", W'(mh), W'(12));
    drain("t2_drain", 50);

    // random m_ready and input gaps over 20 frames
    do_reset();
    mon_en  = 1'b1;
    rand_mr = 1'b1;
    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < 16; i++) frame_buf[i] = {$urandom(), $urandom()};
      send_frame(2'b00, 2'b00, 1'b1);
    end
    drain("t3_drain", 600);
    rand_mr = 1'b0;

    // reset after sample 9 discards the partial frame
    do_reset();
    mon_en  = 1'b1;
    m_ready = 1'b1;
    acc = 0;
    guard = 0;
    while (acc < 10 && guard < 100) begin
      s_valid = 1'b1;
      s_data  = 64'hDEAD_0000_0000_0000 + 64'(acc);
      tick();
      if (s_hs) acc++;
      guard++;
    end
    s_valid = 1'b0;
    rst_n = 1'b0;
    #3;
    check_bit("t4_in_reset_valid", m_valid, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    stall_prev = 1'b0;
    tick();
    check_bit("t4_s_ready", sr_smp, 1'b1);
    check_bit("t4_m_valid", mv_smp, 1'b0);
    for (int i = 0; i < 16; i++) frame_buf[i] = 64'h0000_0100_0000_0000 + 64'(i);
    send_frame(2'b00, 2'b00, 1'b0);
    drain("t4_drain", 50);

`ifdef K_FEEDER_SCALE_EN
    // scaling latched at sample 0 of each frame
    do_reset();
    mon_en  = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) frame_buf[i] = 64'h0000_0500_0000_0000 + 64'(i);
    send_frame(2'd2, 2'd3, 1'b0);
    for (int i = 0; i < 16; i++) frame_buf[i] = 64'h0000_0600_0000_0000 + 64'(i);
    send_frame(2'd1, 2'd1, 1'b0);
    drain("t5_drain", 50);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
